mem_access_stage: RTL

//  MEM stage of the 5-stage MIPS pipeline: consumes EX/MEM register outputs and performs the data-memory load/store.

---
 rtl/mips_mem_pkg.sv | 33 +++
 rtl/mem_access_stage_if.sv | 49 ++++
 rtl/data_memory_array.sv | 29 ++
 rtl/mem_access_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage of the 5-stage MIPS pipeline.
//   accessSizeE : AccessSize encodings (word / half / byte)
//   memStateE   : wait-state FSM states
//   CNT_W       : width of the wait-state counter (WAIT_CYCLES up to 7)
//   extendLoad  : pulls a byte/half lane out of a word and sign/zero-extends it
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } accessSizeE;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } memStateE;

  localparam int unsigned CNT_W = 3;

  function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] offset, input logic zeroExt);
    logic [31:0] lane;
    lane = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: extendLoad = zeroExt ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: extendLoad = zeroExt ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: extendLoad = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM -> MEM/WB signal bundle of the MEM stage.
//   master : upstream side (drives EX/MEM fields, observes stage outputs)
//   slave  : the MEM stage itself
interface mem_access_stage_if;
  // EX/MEM inputs
  logic        RegWriteIn;
  logic        MemToRegIn;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic        BranchIn;
  logic        ZeroIn;
  logic        HiLoToRegIn;
  logic        HiOrLoIn;
  logic [31:0] RHiIn;
  logic [31:0] RLoIn;
  logic [31:0] ALUResultIn;
  logic [31:0] RD2In;
  logic [31:0] AddResultIn;
  logic [4:0]  WriteAddressIn;
  logic [1:0]  AccessSize;
  logic        LoadUnsigned;
  // Branch resolution and hazard
  logic        PCSrc;
  logic [31:0] BranchAddress;
  logic        Stall;
  // MEM/WB outputs
  logic        RegWriteOut;
  logic        MemToRegOut;
  logic [31:0] ReadDataOut;
  logic [31:0] ALUResultOut;
  logic [4:0]  WriteAddrOut;
  logic        Misaligned;

  modport master (
    output RegWriteIn, MemToRegIn, MemReadIn, MemWriteIn, BranchIn, ZeroIn, HiLoToRegIn,
           HiOrLoIn, RHiIn, RLoIn, ALUResultIn, RD2In, AddResultIn, WriteAddressIn,
           AccessSize, LoadUnsigned,
    input  PCSrc, BranchAddress, Stall, RegWriteOut, MemToRegOut, ReadDataOut, ALUResultOut,
           WriteAddrOut, Misaligned
  );

  modport slave (
    input  RegWriteIn, MemToRegIn, MemReadIn, MemWriteIn, BranchIn, ZeroIn, HiLoToRegIn,
           HiOrLoIn, RHiIn, RLoIn, ALUResultIn, RD2In, AddResultIn, WriteAddressIn,
           AccessSize, LoadUnsigned,
    output PCSrc, BranchAddress, Stall, RegWriteOut, MemToRegOut, ReadDataOut, ALUResultOut,
           WriteAddrOut, Misaligned
  );
endinterface

// File: rtl/data_memory_array.sv
// Data memory: 2**ADDR_W 32-bit words, synchronous byte-enabled write, asynchronous read.
//   Clk    : clock, rising edge
//   WrEn   : write strobe
//   ByteEn : byte-lane enables, bit b covers WrData[8b+7:8b]
//   Addr   : word index (shared by read and write)
//   WrData : write data
//   RdData : combinational read of mem[Addr]
module data_memory_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              WrEn,
  input  logic [3:0]        ByteEn,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData
);
  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (WrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (ByteEn[b]) mem[Addr][8*b +: 8] <= WrData[8*b +: 8];
      end
    end
  end

  assign RdData = mem[Addr];
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory load/store with WAIT_CYCLES wait
// states, branch resolution toward IF, and the MEM/WB pipeline register.
//   Clk, Rst : clock (rising edge) and synchronous active-high reset
//   bus      : slave side of mem_access_stage_if (EX/MEM in, PCSrc/BranchAddress/Stall,
//              MEM/WB out)
// Build option: define MEM_SUBWORD_EN for byte/half accesses (AccessSize, LoadUnsigned);
// otherwise every access is a full word.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic               Clk,
  input logic               Rst,
  mem_access_stage_if.slave bus
);
  memStateE         state;
  logic [CNT_W-1:0] waitCnt;
  logic             memOp, stall, misaligned, memWe, isLoad, unusedBits;
  logic [1:0]       offset;
  logic [3:0]       byteEn;
  logic [31:0]      wrData, rdWord, loadData;

  assign offset = bus.ALUResultIn[1:0];
  assign memOp  = bus.MemReadIn | bus.MemWriteIn;

  // Stall is combinational so upstream holds in the very cycle the access is seen.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = memOp && (WAIT_CYCLES != 0);
      WAIT:    stall = 1'b1;
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // DONE is the single non-stalled cycle whose closing edge commits the access.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memOp && (WAIT_CYCLES != 0)) begin
            state   <= (WAIT_CYCLES == 1) ? DONE : WAIT;
            waitCnt <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - CNT_W'(1);
          if (waitCnt == CNT_W'(2)) state <= DONE;
        end
        DONE: begin
          state   <= IDLE;
          waitCnt <= '0;
        end
        default: begin
          state   <= IDLE;
          waitCnt <= '0;
        end
      endcase
    end
  end

`ifdef MEM_SUBWORD_EN
  always_comb begin
    byteEn     = 4'hF;
    wrData     = bus.RD2In;
    misaligned = (offset != 2'b00);
    case (bus.AccessSize)
      SZ_BYTE: begin
        misaligned = 1'b0;
        byteEn     = 4'b0001 << offset;
        wrData     = {4{bus.RD2In[7:0]}};
      end
      SZ_HALF: begin
        misaligned = offset[0];
        byteEn     = offset[1] ? 4'b1100 : 4'b0011;
        wrData     = {2{bus.RD2In[15:0]}};
      end
      default: ;
    endcase
  end
  assign loadData   = extendLoad(rdWord, bus.AccessSize, offset, bus.LoadUnsigned);
  assign unusedBits = ^bus.ALUResultIn[31:ADDR_W+2];
`else
  assign byteEn     = 4'hF;
  assign wrData     = bus.RD2In;
  assign misaligned = (offset != 2'b00);
  assign loadData   = rdWord;
  assign unusedBits = ^{bus.ALUResultIn[31:ADDR_W+2], bus.AccessSize, bus.LoadUnsigned};
`endif

  // Store only on the committing edge so it lands exactly once; reset cancels it.
  assign memWe  = ~stall & bus.MemWriteIn & ~misaligned & ~Rst;
  assign isLoad = bus.MemReadIn & ~bus.MemWriteIn & ~misaligned;

  data_memory_array #(
    .ADDR_W(ADDR_W)
  ) uMem (
    .Clk   (Clk),
    .WrEn  (memWe),
    .ByteEn(byteEn),
    .Addr  (bus.ALUResultIn[ADDR_W+1:2]),
    .WrData(wrData),
    .RdData(rdWord)
  );

  assign bus.PCSrc         = bus.BranchIn & bus.ZeroIn & ~stall;
  assign bus.BranchAddress = bus.AddResultIn;
  assign bus.Stall         = stall;

  // MEM/WB register; a stalled cycle produces an all-zero bubble.
  always_ff @(posedge Clk) begin
    if (Rst || stall) begin
      bus.RegWriteOut  <= 1'b0;
      bus.MemToRegOut  <= 1'b0;
      bus.ReadDataOut  <= '0;
      bus.ALUResultOut <= '0;
      bus.WriteAddrOut <= '0;
      bus.Misaligned   <= 1'b0;
    end else begin
      bus.RegWriteOut  <= bus.RegWriteIn;
      bus.MemToRegOut  <= bus.MemToRegIn;
      bus.ReadDataOut  <= isLoad ? loadData : '0;
      bus.ALUResultOut <= bus.HiLoToRegIn ? (bus.HiOrLoIn ? bus.RHiIn : bus.RLoIn)
                                          : bus.ALUResultIn;
      bus.WriteAddrOut <= bus.WriteAddressIn;
      bus.Misaligned   <= memOp & misaligned;
    end
  end
endmodule
